// File: rtl/tnet_reg_pkg.sv
// Shared constants, FSM state types and byte-strobe merge helper for the
// TNET AXI4-Lite register file.
package tnet_reg_pkg;

    localparam int AXI_DW = 32;
    localparam int AXI_SW = AXI_DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    // Merge new data into an existing word, one byte lane per strobe bit.
    function automatic logic [AXI_DW-1:0] apply_wstrb(
        input logic [AXI_DW-1:0] old_val,
        input logic [AXI_DW-1:0] data,
        input logic [AXI_SW-1:0] strb
    );
        logic [AXI_DW-1:0] res;
        res = old_val;
        for (int b = 0; b < AXI_SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tnet_axil_wr_ch.sv
// AXI4-Lite write channel: independent AW/W capture, commit and B response.
// Presents a single-cycle commit strobe with index, data and strobes.
module tnet_axil_wr_ch
    import tnet_reg_pkg::*;
#(
    parameter int N_RW   = 8,
    parameter int ADDR_W = 6
) (
    input  logic                ps_aclk,
    input  logic                ps_aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [AXI_DW-1:0]   s_axi_wdata,
    input  logic [AXI_SW-1:0]   s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic                wr_commit,
    output logic [ADDR_W-3:0]   wr_idx,
    output logic [AXI_DW-1:0]   wr_data,
    output logic [AXI_SW-1:0]   wr_strb
);

    localparam int IDX_W = ADDR_W - 2;

    w_state_t            state_r;
    w_state_t            state_nx_s;
    logic                rdy_en_r;
    logic                aw_held_r;
    logic                w_held_r;
    logic [IDX_W-1:0]    idx_r;
    logic [AXI_DW-1:0]   data_r;
    logic [AXI_SW-1:0]   strb_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                commit_s;
    logic                mapped_s;
    logic                addr_lsb_unused_s;

    // Readies stay low until the first clock after reset is released.
    assign s_axi_awready = rdy_en_r & ~aw_held_r;
    assign s_axi_wready  = rdy_en_r & ~w_held_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;

    assign aw_hs_s  = s_axi_awvalid & s_axi_awready;
    assign w_hs_s   = s_axi_wvalid & s_axi_wready;
    assign commit_s = (state_r == W_IDLE) & aw_held_r & w_held_r;
    assign mapped_s = ({1'b0, idx_r} < (IDX_W+1)'(N_RW));

    assign wr_commit = commit_s & mapped_s;
    assign wr_idx    = idx_r;
    assign wr_data   = data_r;
    assign wr_strb   = strb_r;

    assign addr_lsb_unused_s = ^s_axi_awaddr[1:0];

    // Write FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            W_IDLE: begin
                if (commit_s) begin
                    state_nx_s = W_RESP;
                end else begin
                    state_nx_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (bvalid_r && s_axi_bready) begin
                    state_nx_s = W_IDLE;
                end else begin
                    state_nx_s = W_RESP;
                end
            end
            default: state_nx_s = W_IDLE;
        endcase
    end

    // Address/data holding registers, B response and state register.
    always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            state_r   <= W_IDLE;
            rdy_en_r  <= 1'b0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            idx_r     <= '0;
            data_r    <= '0;
            strb_r    <= '0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            state_r  <= state_nx_s;
            rdy_en_r <= 1'b1;
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= mapped_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                // A commit cycle never coincides with a capture: both flags are set.
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    idx_r     <= s_axi_awaddr[ADDR_W-1:2];
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    data_r   <= s_axi_wdata;
                    strb_r   <= s_axi_wstrb;
                end
                if (bvalid_r && s_axi_bready) begin
                    bvalid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tnet_axi_regfile.sv
// Parametrised AXI4-Lite register file: RW control words with pulse bits,
// RO status words with optional coherent 64-bit pair reads.
module tnet_axi_regfile
    import tnet_reg_pkg::*;
#(
    parameter int          N_RW       = 8,
    parameter int          N_RO       = 8,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] PULSE_MASK = 32'h0,
    parameter logic [((N_RO/2) > 0 ? (N_RO/2) : 1)-1:0] PAIR_MASK = '0
) (
    input  logic                   ps_aclk,
    input  logic                   ps_aresetn,
    input  logic [ADDR_W-1:0]      s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [ADDR_W-1:0]      s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [32*N_RW-1:0]     rw_regs,
    output logic [N_RW-1:0]        wr_pulse,
    input  logic [32*N_RO-1:0]     ro_regs
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int N_PAIR = (N_RO/2) > 0 ? (N_RO/2) : 1;
    localparam logic [N_RO:0] PAIR_EXT = (N_RO+1)'(PAIR_MASK);

    if ((2 ** IDX_W) < (N_RW + N_RO)) begin : g_addr_w_check
        $error("tnet_axi_regfile: ADDR_W too small for N_RW+N_RO words");
    end

    logic                wr_commit_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [AXI_DW-1:0]   wr_data_s;
    logic [AXI_SW-1:0]   wr_strb_s;

    logic [AXI_DW-1:0]   regs_r    [N_RW];
    logic [AXI_DW-1:0]   base_s    [N_RW];
    logic [N_RW-1:0]     wr_pulse_r;

    r_state_t            rd_state_r;
    r_state_t            rd_state_nx_s;
    logic                ar_rdy_en_r;
    logic                ar_hs_s;
    logic [IDX_W-1:0]    ar_idx_s;
    logic [AXI_DW-1:0]   rd_data_s;
    logic [1:0]          rd_resp_s;
    logic [N_PAIR-1:0]   shadow_ld_s;
    logic [AXI_DW-1:0]   shadow_r  [N_PAIR];
    logic [AXI_DW-1:0]   rdata_r;
    logic [1:0]          rresp_r;
    logic                rvalid_r;
    logic                addr_lsb_unused_s;

    tnet_axil_wr_ch #(
        .N_RW   (N_RW),
        .ADDR_W (ADDR_W)
    ) u_wr_ch (
        .ps_aclk       (ps_aclk),
        .ps_aresetn    (ps_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .wr_commit     (wr_commit_s),
        .wr_idx        (wr_idx_s),
        .wr_data       (wr_data_s),
        .wr_strb       (wr_strb_s)
    );

    for (genvar gi = 0; gi < N_RW; gi++) begin : g_rw_out
        assign rw_regs[32*gi +: 32] = regs_r[gi];
    end

    assign wr_pulse      = wr_pulse_r;
    assign s_axi_arready = ar_rdy_en_r & (rd_state_r == R_IDLE);
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign ar_hs_s       = s_axi_arvalid & s_axi_arready;
    assign ar_idx_s      = s_axi_araddr[ADDR_W-1:2];

    assign addr_lsb_unused_s = ^s_axi_araddr[1:0];

    // Value each register holds absent a write: pulse bits of reg 0 drop to 0.
    always_comb begin
        for (int i = 0; i < N_RW; i++) begin
            base_s[i] = (i == 0) ? (regs_r[i] & ~PULSE_MASK) : regs_r[i];
        end
    end

    // Register array update and one-cycle write strobes.
    always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            for (int i = 0; i < N_RW; i++) begin
                regs_r[i] <= '0;
            end
            wr_pulse_r <= '0;
        end else begin
            for (int i = 0; i < N_RW; i++) begin
                if (wr_commit_s && (wr_idx_s == IDX_W'(i))) begin
                    regs_r[i]     <= apply_wstrb(base_s[i], wr_data_s, wr_strb_s);
                    wr_pulse_r[i] <= 1'b1;
                end else begin
                    regs_r[i]     <= base_s[i];
                    wr_pulse_r[i] <= 1'b0;
                end
            end
        end
    end

    // Read source mux; the even word of a pair also arms its shadow load.
    always_comb begin
        rd_data_s   = '0;
        rd_resp_s   = RESP_SLVERR;
        shadow_ld_s = '0;
        for (int i = 0; i < N_RW; i++) begin
            rd_data_s = (ar_idx_s == IDX_W'(i)) ? regs_r[i] : rd_data_s;
            rd_resp_s = (ar_idx_s == IDX_W'(i)) ? RESP_OKAY : rd_resp_s;
        end
        for (int j = 0; j < N_RO; j++) begin
            if (ar_idx_s == IDX_W'(N_RW + j)) begin
                rd_resp_s = RESP_OKAY;
                if ((j % 2 == 1) && PAIR_EXT[j/2]) begin
                    rd_data_s = shadow_r[j/2];
                end else begin
                    rd_data_s = ro_regs[32*j +: 32];
                end
                if ((j % 2 == 0) && (j + 1 < N_RO) && PAIR_EXT[j/2]) begin
                    shadow_ld_s[j/2] = 1'b1;
                end else begin
                    shadow_ld_s = shadow_ld_s;
                end
            end else begin
                rd_resp_s = rd_resp_s;
            end
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        rd_state_nx_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_nx_s = R_RESP;
                end else begin
                    rd_state_nx_s = R_IDLE;
                end
            end
            R_RESP: begin
                if (rvalid_r && s_axi_rready) begin
                    rd_state_nx_s = R_IDLE;
                end else begin
                    rd_state_nx_s = R_RESP;
                end
            end
            default: rd_state_nx_s = R_IDLE;
        endcase
    end

    // Read response registers, pair shadows and read state register.
    always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            rd_state_r  <= R_IDLE;
            ar_rdy_en_r <= 1'b0;
            rvalid_r    <= 1'b0;
            rdata_r     <= '0;
            rresp_r     <= RESP_OKAY;
            for (int k = 0; k < N_PAIR; k++) begin
                shadow_r[k] <= '0;
            end
        end else begin
            rd_state_r  <= rd_state_nx_s;
            ar_rdy_en_r <= 1'b1;
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
                rresp_r  <= rd_resp_s;
            end else if (rvalid_r && s_axi_rready) begin
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rvalid_r;
            end
            for (int k = 0; k < N_RO/2; k++) begin
                if (ar_hs_s && shadow_ld_s[k]) begin
                    shadow_r[k] <= ro_regs[32*(2*k+1) +: 32];
                end else begin
                    shadow_r[k] <= shadow_r[k];
                end
            end
        end
    end

endmodule
